prio_encoder_stream: RTL and testbench

Parametrised priority-encoder stream block: accepts an N-bit request vector (any number of bits set) over a valid/ready handshake and emits the index of each set bit, lowest index first, one index per accepted output beat. It generalises the 8-to-3 one-hot encoder to arbitrary width, multi-hot input and back-pressure. An all-zero vector produces a single flagged "no valid bit" beat. It sits between request-collection logic and downstream consumers that process one index at a time.

---
 rtl/enc_pkg.sv | 15 +
 rtl/lsb_find.sv | 26 ++
 rtl/prio_encoder_stream.sv | 130 +++++++++++++
 tb/tb_prio_encoder_stream.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and constants for the priority-encoder stream block.
// Holds the drain FSM state encoding and the index-width derivation.
package enc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Index width for an N-bit request vector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lsb_find.sv
// Combinational lowest-set-bit finder: index, found flag and a one-hot mask
// of that bit so the caller can clear it.
module lsb_find
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_found,
  output logic [N-1:0] o_mask
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_mask  = i_vec & (~i_vec + N'(1));
  assign o_found = |i_vec;

  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = W'(i);
    end
  end

endmodule

// File: rtl/prio_encoder_stream.sv
// Priority-encoder stream: emits the index of every set bit of an accepted
// request vector, lowest first. Optional popcount output under ENC_POPCOUNT_EN.
module prio_encoder_stream
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic [W-1:0] idx,
  output logic         last,
  output logic         none,
  output state_t       dbg_state
`ifdef ENC_POPCOUNT_EN
  ,
  output logic [W:0]   cnt
`endif
);

  // Handshake: a beat transfers on a cycle where valid && ready are both high;
  // a valid holder keeps its payload stable until that cycle.

  state_t       r_state;
  logic [N-1:0] r_pend;       // bits still to emit after the beat on idx
  logic         r_idx_valid;
  logic [W-1:0] r_idx;
  logic         r_last;
  logic         r_none;

  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_fin;

  logic [W-1:0] w_ld_idx;
  logic         w_ld_found;
  logic [N-1:0] w_ld_mask;
  logic [N-1:0] w_ld_rest;

  logic [W-1:0] w_dr_idx;
  logic         w_dr_found;
  logic [N-1:0] w_dr_mask;
  logic [N-1:0] w_dr_rest;

  lsb_find #(.N(N)) u_ld_find (
    .i_vec   (req),
    .o_idx   (w_ld_idx),
    .o_found (w_ld_found),
    .o_mask  (w_ld_mask)
  );

  lsb_find #(.N(N)) u_dr_find (
    .i_vec   (r_pend),
    .o_idx   (w_dr_idx),
    .o_found (w_dr_found),
    .o_mask  (w_dr_mask)
  );

  assign w_ld_rest  = req & ~w_ld_mask;
  assign w_dr_rest  = r_pend & ~w_dr_mask;

  assign w_out_fire = r_idx_valid && idx_ready;
  assign w_fin      = w_out_fire && r_last;
  // Ready while the final beat leaves lets the next vector load with no bubble.
  assign req_ready  = !rst && ((r_state == IDLE) || w_fin);
  assign w_in_fire  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_idx_valid <= 1'b0;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_none      <= 1'b0;
    end else if (w_in_fire) begin
      r_state     <= DRAIN;
      r_pend      <= w_ld_rest;
      r_idx_valid <= 1'b1;
      r_idx       <= w_ld_idx;
      r_last      <= (w_ld_rest == '0);
      r_none      <= !w_ld_found;
    end else if (w_out_fire) begin
      if (r_last) begin
        r_state     <= IDLE;
        r_idx_valid <= 1'b0;
      end else begin
        r_pend      <= w_dr_rest;
        r_idx_valid <= w_dr_found;
        r_idx       <= w_dr_idx;
        r_last      <= (w_dr_rest == '0);
      end
    end
  end

  assign idx_valid = r_idx_valid;
  assign idx       = r_idx;
  assign last      = r_last;
  assign none      = r_none;
  assign dbg_state = r_state;

`ifdef ENC_POPCOUNT_EN
  logic [W:0] r_cnt;
  logic [W:0] w_req_cnt;

  always_comb begin
    w_req_cnt = '0;
    for (int i = 0; i < N; i++) begin
      w_req_cnt = w_req_cnt + (W + 1)'(req[i]);
    end
  end

  // Count is captured once per vector and held across all of its beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_in_fire) begin
      r_cnt <= w_req_cnt;
    end
  end

  assign cnt = r_cnt;
`endif

endmodule

// File: tb/tb_prio_encoder_stream.sv
// Self-checking bench for prio_encoder_stream: directed cases then random
// traffic, compared against a queue of expected beats built from each vector.
module tb_prio_encoder_stream;
  import enc_pkg::*;

  localparam int N = 8;
  localparam int W = idx_w(N);

  typedef struct packed {
    logic [W:0]   cnt;
    logic         none;
    logic         last;
    logic [W-1:0] idx;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [N-1:0] req = '0;
  logic         idx_valid;
  logic         idx_ready = 1'b0;
  logic [W-1:0] idx;
  logic         last;
  logic         none;
  state_t       dbg_state;
`ifdef ENC_POPCOUNT_EN
  logic [W:0]   cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  beat_t exp_q[$];

  prio_encoder_stream #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req       (req),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .idx       (idx),
    .last      (last),
    .none      (none),
    .dbg_state (dbg_state)
`ifdef ENC_POPCOUNT_EN
    ,
    .cnt       (cnt)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one beat per set bit in ascending order, or a single none beat.
  task automatic push_vec(input logic [N-1:0] r);
    beat_t b;
    int hi;
    int ones;
    if (r == '0) begin
      b.cnt = '0; b.none = 1'b1; b.last = 1'b1; b.idx = '0;
      exp_q.push_back(b);
    end else begin
      hi = 0;
      ones = $countones(r);
      for (int i = 0; i < N; i++) if (r[i]) hi = i;
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          b.cnt  = (W + 1)'(ones);
          b.none = 1'b0;
          b.last = (i == hi);
          b.idx  = W'(i);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // Driver: one cycle of stimulus, output checks mid-cycle, model update at the edge.
  task automatic step(input logic v, input logic [N-1:0] r, input logic rdy, input logic rs);
    logic exp_valid;
    logic exp_ready;
    logic out_fire;
    logic in_fire;
    @(negedge clk);
    rst = rs; req_valid = v; req = r; idx_ready = rdy;
    #1;
    exp_valid = (exp_q.size() != 0);
    exp_ready = !rs && ((exp_q.size() == 0) || (rdy && exp_q.size() == 1));
    chk_eq("idx_valid", 32'(idx_valid), 32'(exp_valid));
    chk_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    if (exp_valid) begin
      chk_eq("idx",  32'(idx),  32'(exp_q[0].idx));
      chk_eq("last", 32'(last), 32'(exp_q[0].last));
      chk_eq("none", 32'(none), 32'(exp_q[0].none));
`ifdef ENC_POPCOUNT_EN
      chk_eq("cnt",  32'(cnt),  32'(exp_q[0].cnt));
`endif
    end
    out_fire = rdy && exp_valid;
    in_fire  = v && exp_ready;
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
    end else begin
      if (out_fire) void'(exp_q.pop_front());
      if (in_fire) push_vec(r);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * N && exp_q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk_eq("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [N-1:0] r;
    repeat (3) @(posedge clk);
    // Reset state while rst is still high
    step(1'b0, '0, 1'b0, 1'b1);
    chk_eq("rst_idx",  32'(idx),  32'd0);
    chk_eq("rst_last", 32'(last), 32'd0);
    chk_eq("rst_none", 32'(none), 32'd0);
`ifdef ENC_POPCOUNT_EN
    chk_eq("rst_cnt",  32'(cnt),  32'd0);
`endif

    // Single bit, then multi-hot, then all-zero
    step(1'b1, 8'b0000_0100, 1'b1, 1'b0);
    drain();
    step(1'b1, 8'b1010_0010, 1'b1, 1'b0);
    drain();
    step(1'b1, 8'h00, 1'b1, 1'b0);
    drain();
    // Boundary: top bit only
    step(1'b1, 8'h80, 1'b1, 1'b0);
    drain();

    // All bits set with idx_ready pattern 1,0,0,1,...
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, '0, (i % 3) == 0, 1'b0);
    chk_eq("ff_left", 32'(exp_q.size()), 32'd0);

    // Back-to-back vectors with req_valid held
    step(1'b1, 8'h81, 1'b1, 1'b0);
    step(1'b1, 8'h10, 1'b1, 1'b0);
    step(1'b1, 8'h10, 1'b1, 1'b0);
    drain();

    // Reset during the second beat of 8'h0F
    step(1'b1, 8'h0F, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       r = '0;
        1:       r = N'(1) << $urandom_range(0, N - 1);
        default: r = N'($urandom);
      endcase
      step($urandom_range(0, 2) != 0, r, $urandom_range(0, 3) != 0, 1'b0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
